// File: rtl/msk_unload_serializer.sv
// Masked output serializer: captures one full masked block and streams it
// out one masked word at a time over valid/ready. Shares are only stored,
// shifted, forwarded or zeroed, never combined with each other.
//
// state | meaning
// IDLE  | buffer empty and cleared; ready to accept a new block
// SEND  | presenting buffered words; low word of data_buf is on out_data
module msk_unload_serializer #(
    parameter int d      = 2,
    parameter int NWORDS = 4,
    parameter int W      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NWORDS*W*d-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W*d-1:0]           out_data,
    output logic                     out_last
);
    localparam int WD = W * d;
    localparam int BW = NWORDS * WD;
    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   data_buf;
    logic            cnt_last;
    logic            in_fire;
    logic            out_fire;

    assign cnt_last = (cnt == CW'(NWORDS - 1));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a completing block with a new one waiting stays in SEND
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_fire) state_nxt = SEND;
            SEND: if (out_fire && cnt_last && !in_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; out_data is zero in IDLE because the buffer is cleared there
    always_comb begin
        out_valid = (state == SEND);
        out_last  = out_valid && cnt_last;
        in_ready  = (state == IDLE) || (out_valid && out_ready && out_last);
        out_data  = data_buf[WD-1:0];
    end

    // Buffer and word counter: load, shift out with zero fill, or clear on completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_buf <= '0;
            cnt      <= '0;
        end else if (in_fire) begin
            data_buf <= in_data;
            cnt      <= '0;
        end else if (out_fire) begin
            if (cnt_last) begin
                data_buf <= '0;
                cnt      <= '0;
            end else begin
                data_buf <= data_buf >> WD;
                cnt      <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_msk_unload_serializer.sv
// Bench for msk_unload_serializer (d=2, NWORDS=4, W=32). A queue of the
// masked words still owed to the consumer serves as the reference model.
module tb_msk_unload_serializer;
    localparam int D  = 2;
    localparam int NW = 4;
    localparam int W  = 32;
    localparam int WD = W * D;
    localparam int BW = NW * WD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [WD-1:0] out_data;
    logic          out_last;

    int checks   = 0;
    int failures = 0;

    logic [WD-1:0] exp_q[$];
    logic [WD-1:0] got[$];
    logic          stall_prev = 1'b0;
    logic [WD-1:0] prev_data  = '0;

    msk_unload_serializer #(.d(D), .NWORDS(NW), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mask_block(input logic [NW*W-1:0] v, input logic [NW*W-1:0] s0);
        logic [BW-1:0] r;
        for (int i = 0; i < NW * W; i++) begin
            r[2*i]   = s0[i];
            r[2*i+1] = v[i] ^ s0[i];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [WD-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[2*i] ^ w[2*i+1];
        return r;
    endfunction

    function automatic logic [NW*W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [BW-1:0] rand_blk();
        return mask_block(rand128(), rand128());
    endfunction

    task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input logic rst, input logic iv, input logic [BW-1:0] idat, input logic ordy);
        logic          e_valid;
        logic          e_last;
        logic          e_ir;
        logic [WD-1:0] e_data;
        logic          fo;
        logic          fi;
        @(negedge clk);
        rst_n     = rst;
        in_valid  = iv;
        in_data   = idat;
        out_ready = ordy;
        #1;
        e_valid = (exp_q.size() > 0);
        e_last  = (exp_q.size() == 1);
        e_data  = e_valid ? exp_q[0] : '0;
        e_ir    = !e_valid || (ordy && e_last);
        chk("out_valid", WD'(out_valid), WD'(e_valid));
        chk("out_last",  WD'(out_last),  WD'(e_last));
        chk("in_ready",  WD'(in_ready),  WD'(e_ir));
        chk("out_data",  out_data, e_data);
        if (stall_prev && out_valid) chk("stall_hold", out_data, prev_data);
        if (out_valid && ordy) got.push_back(out_data);
        stall_prev = out_valid && !ordy;
        prev_data  = out_data;
        fo = e_valid && ordy;
        fi = iv && e_ir;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (fo) void'(exp_q.pop_front());
            if (fi) for (int k = 0; k < NW; k++) exp_q.push_back(idat[k*WD +: WD]);
        end
    endtask

    logic [BW-1:0] blk_a;
    logic [BW-1:0] blk_b;
    logic [BW-1:0] blk_c;
    logic [W-1:0]  exp_words [NW];
    int            pat [7];

    initial begin
        exp_words[0] = 32'hCCDDEEFF;
        exp_words[1] = 32'h8899AABB;
        exp_words[2] = 32'h44556677;
        exp_words[3] = 32'h00112233;
        pat = '{1, 0, 0, 1, 0, 1, 1};

        // Reset held with in_valid high: nothing may load
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = rand_blk();
        out_ready = 1'b1;
        @(posedge clk);
        cycle(1'b0, 1'b1, rand_blk(), 1'b1);
        cycle(1'b0, 1'b1, rand_blk(), 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);

        // Single known block, consumer always ready
        blk_a = mask_block(128'h00112233_44556677_8899AABB_CCDDEEFF, rand128());
        got.delete();
        cycle(1'b1, 1'b1, blk_a, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1);
        chk("single_count", WD'(got.size()), WD'(NW));
        for (int k = 0; k < NW && k < got.size(); k++)
            chk($sformatf("unmask_w%0d", k), WD'(unmask(got[k])), WD'(exp_words[k]));

        // Backpressure pattern
        blk_b = rand_blk();
        got.delete();
        cycle(1'b1, 1'b1, blk_b, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, '0, pat[i][0]);
        cycle(1'b1, 1'b0, '0, 1'b1);
        chk("bp_handshakes", WD'(got.size()), WD'(NW));
        for (int k = 0; k < NW && k < got.size(); k++)
            chk($sformatf("bp_w%0d", k), got[k], blk_b[k*WD +: WD]);

        // Busy input ignored, then back-to-back load on the last handshake
        blk_a = rand_blk();
        blk_b = rand_blk();
        blk_c = rand_blk();
        got.delete();
        cycle(1'b1, 1'b1, blk_a, 1'b1);
        cycle(1'b1, 1'b1, blk_c, 1'b1);
        cycle(1'b1, 1'b1, blk_c, 1'b0);
        cycle(1'b1, 1'b1, blk_c, 1'b1);
        cycle(1'b1, 1'b1, blk_b, 1'b1);
        cycle(1'b1, 1'b1, blk_b, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        chk("b2b_count", WD'(got.size()), WD'(2 * NW));
        for (int k = 0; k < NW && k + NW < got.size(); k++) begin
            chk($sformatf("b2b_a%0d", k), got[k],      blk_a[k*WD +: WD]);
            chk($sformatf("b2b_b%0d", k), got[k + NW], blk_b[k*WD +: WD]);
        end

        // Reset in the middle of a block, then a fresh block from word 0
        cycle(1'b1, 1'b1, rand_blk(), 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        blk_c = rand_blk();
        got.delete();
        cycle(1'b1, 1'b1, blk_c, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1);
        chk("post_rst_count", WD'(got.size()), WD'(NW));
        if (got.size() > 0) chk("post_rst_w0", got[0], blk_c[WD-1:0]);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1, rand_blk(),
                  $urandom_range(0, 3) != 0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msk_unload_serializer.md
# msk_unload_serializer

Masked output serializer at the result end of the masked AES datapath. Takes one full masked block (all shares, in parallel) from the core when the core signals completion, then streams it out as masked 32-bit words over a valid/ready handshake. Shares are never recombined: the block only stores, shifts and forwards shared bits, so the masking order `d` is preserved end to end.

## Interface
- `d`, default 2: number of shares per logical bit.
- `NWORDS`, default 4: words per block.
- `W`, default 32: logical bits per output word. The block width is `NWORDS*W`.
- Masked bus encoding: share `j` of logical bit `i` sits at bus bit `i*d+j`, so logical word `k` occupies bus bits `[k*W*d +: W*d]`.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `in_valid`, in, 1: a masked block is presented on `in_data`.
- `in_ready`, out, 1: the block accepts `in_data` this cycle.
- `in_data`, in, `NWORDS*W*d`: masked block.
- `out_valid`, out, 1: `out_data` holds a valid masked word.
- `out_ready`, in, 1: the consumer accepts the current word.
- `out_data`, out, `W*d`: current masked word.
- `out_last`, out, 1: the current word is the final word of the block.

## Operation
- State: FSM {IDLE, SEND}; word counter `cnt` of width `clog2(NWORDS)`; buffer `buf` of width `NWORDS*W*d`.
- Input handshake fires when `in_valid && in_ready`. Output handshake fires when `out_valid && out_ready`.
- IDLE:
  - `in_ready=1`, `out_valid=0`.
  - On input handshake: `buf<=in_data`, `cnt<=0`, next state SEND.
- SEND:
  - `out_valid=1`.
  - `out_data=buf[W*d-1:0]`.
  - `out_last=(cnt==NWORDS-1)`.
  - On output handshake with `cnt<NWORDS-1`: `buf` shifts right by `W*d`, zero-filled at the top; `cnt<=cnt+1`.
  - On output handshake with `cnt==NWORDS-1`: the block is complete.
    - If `in_valid` is also high, accept the new block: `in_ready=1`, `buf<=in_data`, `cnt<=0`, stay in SEND. This gives back-to-back throughput.
    - Otherwise: `buf<=0`, `cnt<=0`, go to IDLE.
  - No output handshake: `buf` and `cnt` hold, as an enable-gated register. `out_data` stays stable while `out_valid && !out_ready`.
- `in_ready` equals `(state==IDLE) || (out_valid && out_ready && out_last)`.
- Masking constraints:
  - No logic combines different shares or different bits.
  - The only datapath operations are per-bit load, hold, shift, or zero-gating.
  - Zero-fill and clear are per-bit ANDs with control signals only.
- `in_data` is ignored whenever `in_ready=0`.

## Timing
- Reset (`rst_n=0` at a rising edge) forces:
  - state IDLE, `cnt=0`, `buf=0`;
  - outputs `out_valid=0`, `out_last=0`, `out_data=0`, `in_ready=1` (on the first cycle after reset).
- Reset mid-block discards all remaining words; no partial word is emitted afterwards.
- Latency: the input handshake in cycle N puts word 0 on `out_data` with `out_valid=1` in cycle N+1.
- With `out_ready` held high, words 0..NWORDS-1 appear in cycles N+1..N+NWORDS. `out_last` is high only in cycle N+NWORDS.
- With `in_valid` and `out_ready` held high: one new block every NWORDS cycles, with no idle bubble.
- `out_valid` never drops without an output handshake. `out_data` and `out_last` change only after a handshake or a load.
- In IDLE, `out_data=0`.
- Counter wrap: `cnt` never exceeds NWORDS-1. It returns to 0 only on a block load or block completion.

## Test plan
All cases use `d=2`, `NWORDS=4`, `W=32`.
- Reset: hold `rst_n=0` for 2 cycles while `in_valid=1` -> `out_valid=0`, `out_data=0`, no load. Release -> `in_ready=1`.
- Single block, `out_ready=1`:
  - Load a block whose unmasked value is 0x00112233_44556677_8899AABB_CCDDEEFF, with random share 0 and share 1 = value XOR share 0.
  - Required: 4 words in consecutive cycles, and per-word XOR of the two shares = 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233.
  - `out_last` high only on the 4th word. Returns to IDLE with `out_data=0`.
- Backpressure: toggle `out_ready` in the pattern 1,0,0,1,0,1,1 -> `out_data` stays stable through every stall; exactly 4 handshakes occur; word order is unchanged.
- Back-to-back: `in_valid=1` and `out_ready=1` continuously with blocks A and B -> B's word 0 appears in the cycle after A's last word. `in_ready` pulses exactly on A's last handshake.
- Input ignored while busy: during SEND, drive a different `in_data` with `in_valid=1` before the last word -> `in_ready=0` and the output words remain block A's.
- Reset mid-block: assert `rst_n=0` after word 1 of a block -> next cycle `out_valid=0`, `cnt=0`. A new block then streams starting from its word 0.
